pipe_hold_ctrl: RTL and testbench
=================================

# pipe_hold_ctrl

Central pipeline sequencer for the five-stage core. It produces the `hold_code` consumed by every stage register, including the ID/EX register's `hold_code >= HOLD_CODE_ID` check. It also generates PC redirects and IF/ID flushes, and sequences the multi-cycle cases: load-use stall, data-bus wait with timeout, and trap entry/drain.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: max cycles waiting for `dmem_ack_i` before a bus-error trap.
- `DRAIN_CYCLES`, default 2: cycles allowed for older instructions (EX, MEM) to retire before trap redirect.
- `CAUSE_BUS`, default 4'd5: cause reported on data-bus timeout.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_bypass_i`  in  1  ID instruction depends on a load currently in EX.
- `jmp_flag_i`  in  1  taken jump/branch resolved in ID this cycle.
- `jmp_addr_i`  in  64  jump target.
- `mret_i`  in  1  ID holds MRET.
- `mepc_i`  in  64  CSR mepc.
- `mtvec_i`  in  64  CSR mtvec.
- `decode_except_i`  in  1  ID decode exception.
- `except_cause_i`  in  4  decode exception cause.
- `except_pc_i`  in  64  PC of the ID instruction.
- `dmem_req_i`  in  1  MEM stage has an outstanding bus access.
- `dmem_ack_i`  in  1  bus completes the access this cycle.
- `mem_pc_i`  in  64  PC of the MEM-stage instruction.
- `hold_code_o`  out  3  0=NONE, 1=PC, 2=IF, 3=ID, 4=EX, 5=MEM. Stages numbered at or below the code freeze.
- `bubble_ex_o`  out  1  ID/EX register loads a NOP instead of the decoded instruction.
- `flush_if_o`  out  1  IF/ID register loads a NOP.
- `pc_redirect_o`  out  1  PC loads `pc_target_o`.
- `pc_target_o`  out  64  redirect target.
- `trap_o`  out  1  one-cycle trap-commit pulse to the CSR unit.
- `trap_cause_o`  out  4  latched cause, valid with `trap_o`.
- `trap_epc_o`  out  64  latched faulting PC, valid with `trap_o`.

## Operation
- States: RUN, LSTALL, MWAIT, TDRAIN, TJUMP. Registers:
  - 8-bit wait counter `wcnt`
  - 2-bit drain counter `dcnt`
  - cause/epc latches
  - `resume` (state to return to after MWAIT)
- Outputs are combinational from state and inputs. The listed defaults apply unless overridden: `hold_code_o` = 0, all strobes = 0, `pc_target_o` = 0.
- RUN. Conditions are evaluated in priority order; the first match wins.
  1. `dmem_req_i && !dmem_ack_i`: hold=5, go to MWAIT, `wcnt` = 1, `resume` = RUN. All other requests are ignored.
  2. `decode_except_i`: latch cause and `except_pc_i`, hold=3, `bubble_ex_o` = 1, `dcnt` = 0, go to TDRAIN. Jump and MRET are suppressed.
  3. `load_bypass_i`: hold=3, `bubble_ex_o` = 1, go to LSTALL. Jump is suppressed because its operands are stale; it re-resolves next cycle.
  4. `jmp_flag_i`: `pc_redirect_o` = 1, target = `jmp_addr_i`, `flush_if_o` = 1.
  5. `mret_i`: same as jump, with target = `mepc_i`.
- LSTALL:
  - Lasts exactly one cycle. `load_bypass_i` is ignored, which guarantees forward progress.
  - Rules 1, 2, 4 and 5 apply as in RUN.
  - Next state is RUN unless MWAIT or TDRAIN was entered.
- MWAIT:
  - hold=5 every cycle; `wcnt` increments each cycle.
  - On `dmem_ack_i`: hold=0 that cycle and return to `resume`.
  - If `wcnt == MEM_TIMEOUT` without an ack: latch `CAUSE_BUS` / `mem_pc_i` and go to TJUMP. This overrides any pending decode trap.
- TDRAIN:
  - hold=3 and `bubble_ex_o` = 1.
  - `dcnt` increments; at `DRAIN_CYCLES` go to TJUMP.
  - Any bus wait enters MWAIT with `resume` = TDRAIN; `dcnt` is frozen during the wait.
- TJUMP (one cycle):
  - `pc_redirect_o` = 1, target = `mtvec_i`.
  - `flush_if_o` = 1, `bubble_ex_o` = 1, `trap_o` = 1.
  - Go to RUN.
- Reset, including mid-operation: state = RUN, counters and latches = 0. While `rst` is high, all outputs are forced to 0.

## Timing
- Jump redirect: zero latency; PC and flush take effect at the next edge.
- Load-use: exactly one hold cycle per dependent instruction.
- Decode trap:
  - `trap_o` asserts `DRAIN_CYCLES`+1 cycles after the `decode_except_i` cycle, plus any MWAIT cycles.
  - mtvec fetch begins the following cycle.
- Bus timeout: `trap_o` asserts `MEM_TIMEOUT`+1 cycles after the first unacked `dmem_req_i` cycle.
- An ack arriving in the same cycle as a request is no stall.
- An ack arriving in the cycle `wcnt` reaches `MEM_TIMEOUT` counts as success; no trap.

## Test plan
- Load-use: pulse `load_bypass_i` for 2 cycles in RUN.
  - Required: `hold_code_o` = 3 and bubble for cycle 1 only; cycle 2 (LSTALL) hold = 0.
- Jump plus load-use in the same cycle, `jmp_addr_i` = 0x80000100.
  - Required: no redirect that cycle.
  - Next cycle, with `jmp_flag_i` still high: redirect to 0x80000100 and `flush_if_o` = 1.
- Bus wait: `dmem_req_i` high, ack on the 4th cycle.
  - Required: hold = 5 for 3 cycles; cycle 4 hold = 0; back in RUN.
- Timeout: `MEM_TIMEOUT` = 8, no ack, `mem_pc_i` = 0x1000, `mtvec_i` = 0x2000.
  - Required: at cycle 9, `trap_o` = 1, `trap_cause_o` = 5, `trap_epc_o` = 0x1000, target = 0x2000.
- Decode trap with a bus wait mid-drain.
  - Stimulus: cause = 2, `except_pc_i` = 0x44; a 3-cycle wait in drain cycle 1.
  - Required: `trap_o` 6 cycles after the exception, with cause 2 and epc 0x44.
- Assert `rst` during MWAIT.
  - Required: all outputs 0 immediately; after release, state RUN with hold = 0.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline sequencer: stage hold code, PC redirects, IF/ID flushes,
// load-use stall, data-bus wait with timeout, and trap drain/entry.
module pipe_hold_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [3:0]  CAUSE_BUS    = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_bypass_i,
  input  logic        jmp_flag_i,
  input  logic [63:0] jmp_addr_i,
  input  logic        mret_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] mtvec_i,
  input  logic        decode_except_i,
  input  logic [3:0]  except_cause_i,
  input  logic [63:0] except_pc_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  input  logic [63:0] mem_pc_i,
  output logic [2:0]  hold_code_o,
  output logic        bubble_ex_o,
  output logic        flush_if_o,
  output logic        pc_redirect_o,
  output logic [63:0] pc_target_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic [63:0] trap_epc_o
);

  localparam int unsigned XLEN    = 64;
  localparam int unsigned HOLD_W  = 3;
  localparam int unsigned WCNT_W  = 8;
  localparam int unsigned DCNT_W  = 2;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);
  localparam logic [HOLD_W-1:0] HOLD_MEM  = HOLD_W'(5);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LSTALL = 3'd1,
    ST_MWAIT  = 3'd2,
    ST_TDRAIN = 3'd3,
    ST_TJUMP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  state_t               resume_q, resume_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]      epc_q, epc_d;

  logic [HOLD_W-1:0]    hold_c;
  logic                 bubble_c, flush_c, redirect_c, trap_c;
  logic [XLEN-1:0]      target_c;
  logic                 bus_stall_c;

  assign bus_stall_c = dmem_req_i && !dmem_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      resume_q <= ST_RUN;
      wcnt_q   <= '0;
      dcnt_q   <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // Next-state and combinational strobes
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    wcnt_d     = wcnt_q;
    dcnt_d     = dcnt_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    hold_c     = HOLD_NONE;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    redirect_c = 1'b0;
    target_c   = '0;
    trap_c     = 1'b0;

    unique case (state_q)
      ST_RUN, ST_LSTALL: begin
        if (bus_stall_c) begin
          hold_c   = HOLD_MEM;
          state_d  = ST_MWAIT;
          wcnt_d   = WCNT_W'(1);
          resume_d = ST_RUN;
        end else if (decode_except_i) begin
          cause_d  = except_cause_i;
          epc_d    = except_pc_i;
          hold_c   = HOLD_ID;
          bubble_c = 1'b1;
          dcnt_d   = '0;
          state_d  = ST_TDRAIN;
        end else if (load_bypass_i && (state_q == ST_RUN)) begin
          // Jump operands may be stale; it re-resolves next cycle.
          hold_c   = HOLD_ID;
          bubble_c = 1'b1;
          state_d  = ST_LSTALL;
        end else begin
          state_d = ST_RUN;
          if (jmp_flag_i) begin
            redirect_c = 1'b1;
            flush_c    = 1'b1;
            target_c   = jmp_addr_i;
          end else if (mret_i) begin
            redirect_c = 1'b1;
            flush_c    = 1'b1;
            target_c   = mepc_i;
          end
        end
      end
      ST_MWAIT: begin
        hold_c = HOLD_MEM;
        if (dmem_ack_i) begin
          hold_c  = HOLD_NONE;
          state_d = resume_q;
        end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
          // Bus error wins over any decode trap being drained.
          cause_d = CAUSE_BUS;
          epc_d   = mem_pc_i;
          state_d = ST_TJUMP;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_TDRAIN: begin
        if (bus_stall_c) begin
          hold_c   = HOLD_MEM;
          state_d  = ST_MWAIT;
          wcnt_d   = WCNT_W'(1);
          resume_d = ST_TDRAIN;
        end else begin
          hold_c   = HOLD_ID;
          bubble_c = 1'b1;
          dcnt_d   = dcnt_q + DCNT_W'(1);
          if ((3'({1'b0, dcnt_q}) + 3'd1) == 3'(DRAIN_CYCLES)) begin
            state_d = ST_TJUMP;
          end
        end
      end
      ST_TJUMP: begin
        redirect_c = 1'b1;
        target_c   = mtvec_i;
        flush_c    = 1'b1;
        bubble_c   = 1'b1;
        trap_c     = 1'b1;
        state_d    = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Everything reads as zero while reset is held.
  assign hold_code_o   = rst ? HOLD_NONE : hold_c;
  assign bubble_ex_o   = !rst && bubble_c;
  assign flush_if_o    = !rst && flush_c;
  assign pc_redirect_o = !rst && redirect_c;
  assign pc_target_o   = rst ? '0 : target_c;
  assign trap_o        = !rst && trap_c;
  assign trap_cause_o  = rst ? '0 : cause_q;
  assign trap_epc_o    = rst ? '0 : epc_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: per-cycle expectations are queued as
// stimulus is applied, then popped and checked against the outputs.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_bypass_i, jmp_flag_i, mret_i, decode_except_i;
  logic        dmem_req_i, dmem_ack_i;
  logic [63:0] jmp_addr_i, mepc_i, mtvec_i, except_pc_i, mem_pc_i;
  logic [3:0]  except_cause_i;
  logic [2:0]  hold_code_o;
  logic        bubble_ex_o, flush_if_o, pc_redirect_o, trap_o;
  logic [63:0] pc_target_o, trap_epc_o;
  logic [3:0]  trap_cause_o;

  typedef struct {
    string       tag;
    logic [2:0]  hold;
    logic        bubble;
    logic        flush;
    logic        redir;
    logic [63:0] target;
    logic        trap;
    logic        chk_info;
    logic [3:0]  cause;
    logic [63:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  pipe_hold_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(2), .CAUSE_BUS(4'd5)) dut (
    .clk(clk), .rst(rst),
    .load_bypass_i(load_bypass_i), .jmp_flag_i(jmp_flag_i), .jmp_addr_i(jmp_addr_i),
    .mret_i(mret_i), .mepc_i(mepc_i), .mtvec_i(mtvec_i),
    .decode_except_i(decode_except_i), .except_cause_i(except_cause_i),
    .except_pc_i(except_pc_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .mem_pc_i(mem_pc_i), .hold_code_o(hold_code_o), .bubble_ex_o(bubble_ex_o),
    .flush_if_o(flush_if_o), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
  endtask

  task automatic clr();
    load_bypass_i = 1'b0; jmp_flag_i = 1'b0; mret_i = 1'b0; decode_except_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  // Queue the expectation for the current cycle, check it, advance a cycle.
  task automatic cyc(input string tag, input logic [2:0] h, input logic b = 1'b0,
                     input logic f = 1'b0, input logic r = 1'b0,
                     input logic [63:0] t = 64'h0, input logic tr = 1'b0,
                     input logic ci = 1'b0, input logic [3:0] c = 4'h0,
                     input logic [63:0] e = 64'h0);
    exp_t x;
    x.tag = tag; x.hold = h; x.bubble = b; x.flush = f; x.redir = r;
    x.target = t; x.trap = tr; x.chk_info = ci; x.cause = c; x.epc = e;
    exp_q.push_back(x);
    #1;
    x = exp_q.pop_front();
    chk(x.tag, "hold", 64'(hold_code_o), 64'(x.hold));
    chk(x.tag, "bubble", 64'(bubble_ex_o), 64'(x.bubble));
    chk(x.tag, "flush", 64'(flush_if_o), 64'(x.flush));
    chk(x.tag, "redir", 64'(pc_redirect_o), 64'(x.redir));
    chk(x.tag, "target", pc_target_o, x.target);
    chk(x.tag, "trap", 64'(trap_o), 64'(x.trap));
    if (x.chk_info) begin
      chk(x.tag, "cause", 64'(trap_cause_o), 64'(x.cause));
      chk(x.tag, "epc", trap_epc_o, x.epc);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    jmp_addr_i = 64'h0; mepc_i = 64'h0; mtvec_i = 64'h2000;
    except_pc_i = 64'h0; except_cause_i = 4'h0; mem_pc_i = 64'h1000;
    jmp_flag_i = 1'b1; jmp_addr_i = 64'hdead;
    cyc("reset", 3'd0, 0, 0, 0, 64'h0, 0, 1, 4'h0, 64'h0);

    rst = 1'b0; clr();
    cyc("idle", 3'd0);

    // Load-use held two cycles: only the first one stalls
    load_bypass_i = 1'b1;
    cyc("lu1", 3'd3, 1);
    cyc("lu2", 3'd0);
    clr();
    cyc("lu_idle", 3'd0);

    // Jump coinciding with load-use re-resolves the following cycle
    load_bypass_i = 1'b1; jmp_flag_i = 1'b1; jmp_addr_i = 64'h8000_0100;
    cyc("jlu1", 3'd3, 1);
    cyc("jlu2", 3'd0, 0, 1, 1, 64'h8000_0100);
    clr();

    jmp_flag_i = 1'b1; jmp_addr_i = 64'h1234;
    cyc("jmp", 3'd0, 0, 1, 1, 64'h1234);
    clr(); mret_i = 1'b1; mepc_i = 64'h555;
    cyc("mret", 3'd0, 0, 1, 1, 64'h555);
    jmp_flag_i = 1'b1; jmp_addr_i = 64'h777;
    cyc("jmp_over_mret", 3'd0, 0, 1, 1, 64'h777);
    clr();

    // Bus wait acked on the 4th cycle
    dmem_req_i = 1'b1;
    cyc("bw1", 3'd5);
    cyc("bw2", 3'd5);
    cyc("bw3", 3'd5);
    dmem_ack_i = 1'b1;
    cyc("bw4", 3'd0);
    clr(); load_bypass_i = 1'b1;
    cyc("bw_run", 3'd3, 1);
    clr();
    cyc("bw_lstall", 3'd0);

    // Same-cycle ack is no stall; jump goes through
    dmem_req_i = 1'b1; dmem_ack_i = 1'b1; jmp_flag_i = 1'b1; jmp_addr_i = 64'h40;
    cyc("ack_same", 3'd0, 0, 1, 1, 64'h40);
    clr();

    // Timeout: no ack, trap 9 cycles after first unacked request
    dmem_req_i = 1'b1;
    for (int i = 0; i < 9; i++) cyc($sformatf("to%0d", i), 3'd5);
    clr(); dmem_req_i = 1'b1;
    cyc("to_trap", 3'd0, 1, 1, 1, 64'h2000, 1, 1, 4'd5, 64'h1000);
    clr();
    cyc("to_after", 3'd0);

    // Ack in the very cycle the counter reaches the timeout: success
    dmem_req_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc($sformatf("edge%0d", i), 3'd5);
    dmem_ack_i = 1'b1;
    cyc("edge_ack", 3'd0);
    clr();
    cyc("edge_notrap", 3'd0);

    // Decode trap with a 3-cycle bus wait in drain cycle 1
    decode_except_i = 1'b1; except_cause_i = 4'd2; except_pc_i = 64'h44;
    jmp_flag_i = 1'b1; jmp_addr_i = 64'h999;
    cyc("dt0", 3'd3, 1);
    clr(); dmem_req_i = 1'b1;
    cyc("dt1_wait", 3'd5);
    cyc("dt2_wait", 3'd5);
    dmem_ack_i = 1'b1;
    cyc("dt3_ack", 3'd0);
    clr();
    cyc("dt4", 3'd3, 1);
    cyc("dt5", 3'd3, 1);
    cyc("dt6_trap", 3'd0, 1, 1, 1, 64'h2000, 1, 1, 4'd2, 64'h44);
    cyc("dt_after", 3'd0);

    // Reset asserted mid-wait
    dmem_req_i = 1'b1;
    cyc("rw0", 3'd5);
    cyc("rw1", 3'd5);
    rst = 1'b1;
    cyc("rw_rst", 3'd0, 0, 0, 0, 64'h0, 0, 1, 4'h0, 64'h0);
    rst = 1'b0; clr();
    cyc("rw_rel", 3'd0, 0, 0, 0, 64'h0, 0, 1, 4'h0, 64'h0);
    load_bypass_i = 1'b1;
    cyc("rw_run", 3'd3, 1);
    clr();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
